// File: rtl/sramx_responder_if.sv
// Request/response bundle between a bus-to-SRAMx converter (master) and the SRAM end (slave).
interface sramx_responder_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (output en, wen, addr, wdata, input rdata, rvalid);
  modport slave  (input en, wen, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/sramx_responder.sv
// SRAMx slave model: byte-enabled word RAM with window check, fixed-latency response pipeline and counters.
// Optional macro SRAMX_WRITE_FIRST_EN makes write responses return the merged (post-write) word.
module sramx_responder #(
  parameter int          ADDR_WIDTH   = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  sramx_responder_if.slave   bus,
  output logic               oob,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("sramx_responder: READ_LATENCY must be in 1..4");
  end

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return m;
  endfunction

  logic [31:0]           mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  hit;
  logic                  req;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  unused_addr_bits;

  assign idx              = bus.addr[ADDR_WIDTH+1:2];
  assign hit              = (bus.addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign req              = bus.en & ~reset;
  assign wr_acc           = req & hit & (|bus.wen);
  assign rd_acc           = req & hit & ~(|bus.wen);
  assign unused_addr_bits = ^{bus.addr[1:0], BASE_ADDR[ADDR_WIDTH+1:0]};

  // Stage 0: block RAM, read-first synchronous read and byte-enabled write on the same index
  logic [31:0] ram_q;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wen[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
    ram_q <= mem[idx];
  end

  logic        vld_p0;
  logic        hit_p0;
  logic [31:0] dat_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      hit_p0 <= 1'b0;
    end else begin
      vld_p0 <= bus.en;
      hit_p0 <= bus.en & hit;
    end
  end

`ifdef SRAMX_WRITE_FIRST_EN
  logic [3:0]  wen_p0;
  logic [31:0] wdata_p0;

  always_ff @(posedge clk) begin
    wen_p0   <= bus.wen;
    wdata_p0 <= bus.wdata;
  end

  assign dat_p0 = hit_p0 ? merge_bytes(ram_q, wdata_p0, wen_p0) : 32'h0;
`else
  // Out-of-window and idle slots are forced to zero so rdata never shows stale RAM output
  assign dat_p0 = hit_p0 ? ram_q : 32'h0;
`endif

  // Stages 1..READ_LATENCY-1: plain shift flops behind the RAM
  if (READ_LATENCY == 1) begin : g_lat1
    assign bus.rvalid = vld_p0;
    assign bus.rdata  = dat_p0;
  end else begin : g_latn
    logic [READ_LATENCY-1:1] vld_pl;
    logic [31:0]             dat_pl [1:READ_LATENCY-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_pl <= '0;
        for (int s = 1; s < READ_LATENCY; s++) dat_pl[s] <= 32'h0;
      end else begin
        vld_pl[1] <= vld_p0;
        dat_pl[1] <= dat_p0;
        for (int s = 2; s < READ_LATENCY; s++) begin
          vld_pl[s] <= vld_pl[s-1];
          dat_pl[s] <= dat_pl[s-1];
        end
      end
    end

    assign bus.rvalid = vld_pl[READ_LATENCY-1];
    assign bus.rdata  = dat_pl[READ_LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      oob      <= 1'b0;
      rd_count <= 32'h0;
      wr_count <= 32'h0;
    end else begin
      if (bus.en && !hit) oob <= 1'b1;
      if (rd_acc) rd_count <= rd_count + 32'd1;
      if (wr_acc) wr_count <= wr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_sramx_responder.sv
// Scoreboard bench for sramx_responder at READ_LATENCY=3 with a window based at 0x8000_0000.
module tb_sramx_responder;
  localparam int          LAT = 3;
  localparam logic [31:0] B   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        oob;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  sramx_responder_if bus ();

  sramx_responder #(.ADDR_WIDTH(12), .BASE_ADDR(B), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .oob(oob), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          due;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request (or idle slot) for one cycle and queue its expected response
  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input bit chk);
    exp_t x;
    @(posedge clk); #1;
    bus.en = e; bus.wen = w; bus.addr = a; bus.wdata = d;
    if (e && !reset) begin
      x.data = exp; x.chk = chk; x.due = cyc + LAT;
      sb.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  // Monitor: every cycle either pops a response or requires a zero bubble
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (bus.rvalid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid: got rdata %h with no request pending (cycle %0d)", bus.rdata, cyc);
        end else begin
          exp_t x;
          x = sb.pop_front();
          check("resp_latency", cyc, x.due);
          if (x.chk) check("resp_data", bus.rdata, x.data);
        end
      end else begin
        check("bubble_rvalid", {31'h0, bus.rvalid}, 32'h0);
        check("bubble_rdata", bus.rdata, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within bound");
    $fatal(1, "timeout");
  end

  logic [31:0] wr1_exp, wr2_exp, wr3_exp, wr4_exp;

  initial begin
`ifdef SRAMX_WRITE_FIRST_EN
    wr1_exp = 32'hDEADBEEF;
    wr2_exp = 32'hDE22BE44;
    wr3_exp = 32'hDEADBEEF;
    wr4_exp = 32'hDEADBEAB;
`else
    wr1_exp = 32'h0;
    wr2_exp = 32'hDEADBEEF;
    wr3_exp = 32'hDE22BE44;
    wr4_exp = 32'hDEADBEEF;
`endif
    reset = 1'b1;
    bus.en = 1'b0; bus.wen = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    idle(5);
    check("reset_oob", {31'h0, oob}, 32'h0);
    check("reset_rd_count", rd_count, 32'h0);
    check("reset_wr_count", wr_count, 32'h0);

    // Full write then read, then byte-lane write then read on consecutive cycles
`ifdef SRAMX_WRITE_FIRST_EN
    drive(1'b1, 4'hF, B + 32'h10, 32'hDEADBEEF, wr1_exp, 1'b1);
`else
    drive(1'b1, 4'hF, B + 32'h10, 32'hDEADBEEF, wr1_exp, 1'b0);
`endif
    drive(1'b1, 4'h0, B + 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
    idle(LAT + 1);
    check("rd_count_1", rd_count, 32'd1);
    check("wr_count_1", wr_count, 32'd1);
    drive(1'b1, 4'b0101, B + 32'h10, 32'h11223344, wr2_exp, 1'b1);
    drive(1'b1, 4'h0, B + 32'h10, 32'h0, 32'hDE22BE44, 1'b1);

    // Preload and stream three reads back to back
    drive(1'b1, 4'hF, B + 32'h0, 32'd1, 32'h0, 1'b0);
    drive(1'b1, 4'hF, B + 32'h4, 32'd2, 32'h0, 1'b0);
    drive(1'b1, 4'hF, B + 32'h8, 32'd3, 32'h0, 1'b0);
    drive(1'b1, 4'h0, B + 32'h0, 32'h0, 32'd1, 1'b1);
    drive(1'b1, 4'h0, B + 32'h4, 32'h0, 32'd2, 1'b1);
    drive(1'b1, 4'h0, B + 32'h8, 32'h0, 32'd3, 1'b1);
    idle(LAT + 1);
    check("rd_count_stream", rd_count, 32'd5);
    check("wr_count_stream", wr_count, 32'd5);
    check("oob_before", {31'h0, oob}, 32'h0);

    // Out of window: write aliasing index 0 is dropped, read outside window returns zero
    drive(1'b1, 4'hF, 32'h8000_4000, 32'hCAFEF00D, 32'h0, 1'b1);
    drive(1'b1, 4'h0, B + 32'h0, 32'h0, 32'd1, 1'b1);
    drive(1'b1, 4'h0, 32'h0000_0010, 32'h0, 32'h0, 1'b1);
    idle(LAT + 3);
    check("oob_sticky", {31'h0, oob}, 32'h1);
    check("rd_count_oob", rd_count, 32'd6);
    check("wr_count_oob", wr_count, 32'd5);

    // Restore 0x10, issue a read, then reset while it is in flight with a request presented
    drive(1'b1, 4'hF, B + 32'h10, 32'hDEADBEEF, wr3_exp, 1'b1);
    idle(LAT + 1);
    drive(1'b1, 4'h0, B + 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.en = 1'b1; bus.wen = 4'hF; bus.addr = B + 32'h4; bus.wdata = 32'h55;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.en = 1'b0; bus.wen = 4'h0;
    check("post_reset_oob", {31'h0, oob}, 32'h0);
    check("post_reset_rd_count", rd_count, 32'h0);
    check("post_reset_wr_count", wr_count, 32'h0);
    idle(LAT + 1);

    drive(1'b1, 4'b0001, B + 32'h10, 32'h0000_00AB, wr4_exp, 1'b1);
    drive(1'b1, 4'h0, B + 32'h4, 32'h0, 32'd2, 1'b1);
    drive(1'b1, 4'h0, B + 32'h10, 32'h0, 32'hDEADBEAB, 1'b1);
    idle(LAT + 2);
    check("final_rd_count", rd_count, 32'd2);
    check("final_wr_count", wr_count, 32'd1);
    check("final_oob", {31'h0, oob}, 32'h0);
    check("responses_outstanding", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
